// File: rtl/vc_controller.sv
// Control FSM for an 8-way fully-associative victim cache: serves L1 lookups (swap-out on hit)
// and L1 victim inserts, writing a dirty VC victim back to memory before overwriting its way.
//
// state   | meaning
// IDLE    | wait for l1 read (priority) or write; register request tag
// LOOKUP  | tag compare and array read strobes active
// COMPARE | lookup: resolve hit; insert: pick target way
// WB      | dirty victim writeback, wait for pmem_resp
// INSERT  | load tag/data/metadata of the target way
// RESP    | one-cycle completion pulse, hit/hit_dirty valid
module vc_controller #(
  parameter int S_OFFSET         = 5,
  parameter int TAG_WIDTH        = 27,
  parameter int SIZE_OF_VC       = 8,
  parameter int NUM_MUX_SEL_BITS = 4,
  parameter int NUM_OF_PLRU_BITS = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_l1_vc_read,
  input  logic                              i_l1_vc_write,
  input  logic [31:0]                       i_l1_vc_address,
  input  logic                              i_l1_vc_dirty,
  output logic                              o_vc_resp,
  output logic                              o_vc_hit,
  output logic                              o_vc_hit_dirty,
  input  logic [SIZE_OF_VC-1:0]             i_vc_tag_hit,
  input  logic [SIZE_OF_VC-1:0]             i_vc_valid_dataout,
  input  logic [SIZE_OF_VC-1:0]             i_vc_dirty_dataout,
  input  logic [NUM_OF_PLRU_BITS-1:0]       i_vc_plru_dataout,
  input  logic [TAG_WIDTH*SIZE_OF_VC-1:0]   i_vc_tag_dataout,
  output logic                              o_vc_tag_cmp,
  output logic                              o_vc_datastore_read,
  output logic                              o_vc_valid_read,
  output logic                              o_vc_dirty_read,
  output logic                              o_vc_plru_read,
  output logic                              o_vc_tag_write,
  output logic [TAG_WIDTH-1:0]              o_vc_tag_store_datain,
  output logic [SIZE_OF_VC-1:0]             o_vc_tag_store_ld_mask,
  output logic [SIZE_OF_VC-1:0]             o_vc_datastore_ld_mask,
  output logic [SIZE_OF_VC-1:0]             o_vc_valid_ld,
  output logic [SIZE_OF_VC-1:0]             o_vc_dirty_ld,
  output logic                              o_vc_valid_datain,
  output logic                              o_vc_dirty_datain,
  output logic                              o_vc_plru_ld,
  output logic [NUM_OF_PLRU_BITS-1:0]       o_vc_plru_datain,
  output logic [NUM_MUX_SEL_BITS-1:0]       o_vc_datamux_sel,
  output logic                              o_pmem_write,
  output logic [31:0]                       o_pmem_address,
  input  logic                              i_pmem_resp
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_RESP, S_WB, S_INSERT
  } state_t;

  state_t                      r_state;
  logic                        r_is_insert;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic [NUM_OF_PLRU_BITS-1:0] r_way;

  logic [SIZE_OF_VC-1:0]       w_hit_vec;
  logic                        w_hit;
  logic [NUM_OF_PLRU_BITS-1:0] w_hit_way;
  logic [SIZE_OF_VC-1:0]       w_invalid;
  logic [NUM_OF_PLRU_BITS-1:0] w_ins_way;
  logic                        w_victim_dirty;
  logic [TAG_WIDTH-1:0]        w_victim_tag;
  logic [NUM_OF_PLRU_BITS-1:0] w_load_way;
  logic [SIZE_OF_VC-1:0]       w_load_mask;
  logic                        w_unused;

  function automatic logic [NUM_OF_PLRU_BITS-1:0] f_low_idx(input logic [SIZE_OF_VC-1:0] v);
    f_low_idx = '0;
    for (int i = SIZE_OF_VC - 1; i >= 0; i--)
      if (v[i]) f_low_idx = i[NUM_OF_PLRU_BITS-1:0];
  endfunction

  function automatic logic [SIZE_OF_VC-1:0] f_onehot(input logic [NUM_OF_PLRU_BITS-1:0] w);
    f_onehot    = '0;
    f_onehot[w] = 1'b1;
  endfunction

  assign w_hit_vec      = i_vc_tag_hit & i_vc_valid_dataout;
  assign w_hit          = |w_hit_vec;
  assign w_hit_way      = f_low_idx(w_hit_vec);
  assign w_invalid      = ~i_vc_valid_dataout;
  assign w_ins_way      = (|w_invalid) ? f_low_idx(w_invalid) : i_vc_plru_dataout;
  assign w_victim_dirty = i_vc_valid_dataout[w_ins_way] & i_vc_dirty_dataout[w_ins_way];
  assign w_victim_tag   = i_vc_tag_dataout[TAG_WIDTH*w_ins_way +: TAG_WIDTH];
  // After a writeback the target way is already latched; otherwise it is being resolved now.
  assign w_load_way     = (r_state == S_WB) ? r_way : w_ins_way;
  assign w_load_mask    = f_onehot(w_load_way);
  assign w_unused       = ^i_l1_vc_address[S_OFFSET-1:0];

  assign o_vc_tag_store_datain = r_tag;
  assign o_vc_datamux_sel      = {{(NUM_MUX_SEL_BITS-NUM_OF_PLRU_BITS){1'b0}}, r_way};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state                <= S_IDLE;
      r_is_insert            <= 1'b0;
      r_tag                  <= '0;
      r_way                  <= '0;
      o_vc_resp              <= 1'b0;
      o_vc_hit               <= 1'b0;
      o_vc_hit_dirty         <= 1'b0;
      o_vc_tag_cmp           <= 1'b0;
      o_vc_datastore_read    <= 1'b0;
      o_vc_valid_read        <= 1'b0;
      o_vc_dirty_read        <= 1'b0;
      o_vc_plru_read         <= 1'b0;
      o_vc_tag_write         <= 1'b0;
      o_vc_tag_store_ld_mask <= '0;
      o_vc_datastore_ld_mask <= '0;
      o_vc_valid_ld          <= '0;
      o_vc_dirty_ld          <= '0;
      o_vc_valid_datain      <= 1'b0;
      o_vc_dirty_datain      <= 1'b0;
      o_vc_plru_ld           <= 1'b0;
      o_vc_plru_datain       <= '0;
      o_pmem_write           <= 1'b0;
      o_pmem_address         <= '0;
    end else begin
      o_vc_resp              <= 1'b0;
      o_vc_hit               <= 1'b0;
      o_vc_hit_dirty         <= 1'b0;
      o_vc_tag_cmp           <= 1'b0;
      o_vc_datastore_read    <= 1'b0;
      o_vc_valid_read        <= 1'b0;
      o_vc_dirty_read        <= 1'b0;
      o_vc_plru_read         <= 1'b0;
      o_vc_tag_write         <= 1'b0;
      o_vc_tag_store_ld_mask <= '0;
      o_vc_datastore_ld_mask <= '0;
      o_vc_valid_ld          <= '0;
      o_vc_dirty_ld          <= '0;
      o_vc_valid_datain      <= 1'b0;
      o_vc_dirty_datain      <= 1'b0;
      o_vc_plru_ld           <= 1'b0;
      o_vc_plru_datain       <= '0;

      case (r_state)
        S_IDLE: begin
          if (i_l1_vc_read) begin
            r_tag               <= i_l1_vc_address[31:S_OFFSET];
            r_is_insert         <= 1'b0;
            o_vc_tag_cmp        <= 1'b1;
            o_vc_datastore_read <= 1'b1;
            o_vc_valid_read     <= 1'b1;
            o_vc_dirty_read     <= 1'b1;
            o_vc_plru_read      <= 1'b1;
            r_state             <= S_LOOKUP;
          end else if (i_l1_vc_write) begin
            r_tag       <= i_l1_vc_address[31:S_OFFSET];
            r_is_insert <= 1'b1;
            r_state     <= S_COMPARE;
          end
        end

        S_LOOKUP: r_state <= S_COMPARE;

        S_COMPARE: begin
          if (!r_is_insert) begin
            r_way     <= w_hit_way;
            o_vc_resp <= 1'b1;
            o_vc_hit  <= w_hit;
            if (w_hit) begin
              // Line moves back to L1, so the VC copy is invalidated.
              o_vc_hit_dirty    <= i_vc_dirty_dataout[w_hit_way];
              o_vc_valid_ld     <= f_onehot(w_hit_way);
              o_vc_valid_datain <= 1'b0;
              o_vc_plru_ld      <= 1'b1;
              o_vc_plru_datain  <= w_hit_way;
            end
            r_state <= S_RESP;
          end else begin
            r_way <= w_ins_way;
            if (w_victim_dirty) begin
              o_pmem_write   <= 1'b1;
              o_pmem_address <= {w_victim_tag, {S_OFFSET{1'b0}}};
              r_state        <= S_WB;
            end else begin
              o_vc_tag_write         <= 1'b1;
              o_vc_tag_store_ld_mask <= w_load_mask;
              o_vc_datastore_ld_mask <= w_load_mask;
              o_vc_valid_ld          <= w_load_mask;
              o_vc_dirty_ld          <= w_load_mask;
              o_vc_valid_datain      <= 1'b1;
              o_vc_dirty_datain      <= i_l1_vc_dirty;
              o_vc_plru_ld           <= 1'b1;
              o_vc_plru_datain       <= w_load_way;
              r_state                <= S_INSERT;
            end
          end
        end

        S_WB: begin
          if (i_pmem_resp) begin
            o_pmem_write           <= 1'b0;
            o_pmem_address         <= '0;
            o_vc_tag_write         <= 1'b1;
            o_vc_tag_store_ld_mask <= w_load_mask;
            o_vc_datastore_ld_mask <= w_load_mask;
            o_vc_valid_ld          <= w_load_mask;
            o_vc_dirty_ld          <= w_load_mask;
            o_vc_valid_datain      <= 1'b1;
            o_vc_dirty_datain      <= i_l1_vc_dirty;
            o_vc_plru_ld           <= 1'b1;
            o_vc_plru_datain       <= w_load_way;
            r_state                <= S_INSERT;
          end
        end

        S_INSERT: begin
          o_vc_resp <= 1'b1;
          r_state   <= S_RESP;
        end

        S_RESP:  r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_single_hit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == S_COMPARE && !r_is_insert) |-> $onehot0(w_hit_vec));

endmodule
